// File: rtl/adc_stream_packetizer.sv
// adc_stream_packetizer: packs pairs of 16-bit ADC samples into 32-bit
// AXI4-Stream beats for the DMA, ending each packet with TLAST.
// Optional build macro TEST_PATTERN_EN replaces smp_data with an internal
// 16-bit counter so the DMA path can be checked without a live ADC.
module adc_stream_packetizer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SIZE_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] packet_size,
  input  logic              smp_valid,
  input  logic [15:0]       smp_data,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [SIZE_W-1:0] beats_reg, wr_cnt_reg, rd_cnt_reg;
  logic              half_reg;
  logic [15:0]       low_reg;
  logic              overflow_reg, done_reg;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;

  logic [SIZE_W-1:0] beats_in;
  logic [15:0]       sample;
  logic              start_ok, empty, full, pop, push, drop, pair_done;
  logic              is_last, final_hs;

  // Byte count to beat count; the two low bits never form a whole beat.
  logic unused_size;
  assign unused_size = ^packet_size[1:0];
  assign beats_in    = {2'b00, packet_size[SIZE_W-1:2]};

  assign start_ok  = start && (state_reg == IDLE) && (beats_in != '0);
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop       = !empty && m_axis_tready;
  assign pair_done = (state_reg == CAPTURE) && smp_valid && half_reg;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = pair_done && (!full || pop);
  assign drop      = pair_done && full && !pop;
  assign is_last   = (rd_cnt_reg == beats_reg - SIZE_W'(1));
  assign final_hs  = pop && is_last && (state_reg == DRAIN);

`ifdef TEST_PATTERN_EN
  logic [15:0] pat_reg;
  logic        unused_smp;
  assign unused_smp = ^smp_data;

  // Test pattern counter: restarts per packet, advances per captured sample.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      pat_reg <= '0;
    end else if ((state_reg == CAPTURE) && smp_valid) begin
      pat_reg <= pat_reg + 16'd1;
    end
  end

  assign sample = pat_reg;
`else
  assign sample = smp_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: capture until all beats are queued, then drain.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_ok) state_next = CAPTURE;
      CAPTURE: if (push && (wr_cnt_reg + SIZE_W'(1) == beats_reg)) state_next = DRAIN;
      DRAIN:   if (final_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Packet bookkeeping: beat counters, sample pairing, sticky overflow, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_reg    <= '0;
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      half_reg     <= 1'b0;
      low_reg      <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= final_hs;
      if (start_ok) begin
        beats_reg    <= beats_in;
        wr_cnt_reg   <= '0;
        rd_cnt_reg   <= '0;
        half_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if ((state_reg == CAPTURE) && smp_valid) begin
          half_reg <= !half_reg;
          if (!half_reg) low_reg <= sample;
        end
        if (push) wr_cnt_reg <= wr_cnt_reg + SIZE_W'(1);
        if (drop) overflow_reg <= 1'b1;
        if (pop)  rd_cnt_reg <= rd_cnt_reg + SIZE_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {sample, low_reg};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // First-word-fall-through output; data forced to zero when nothing is queued.
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? 32'h0 : mem[rd_ptr_reg];
  assign m_axis_tlast  = !empty && is_last;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign overflow      = overflow_reg;

endmodule
